// File: rtl/phy_eq_train_ctrl.sv
// LMS equalizer sequencer: PRBS7 training, decision-directed tracking, retrain and fail on loss of lock.
// Optional macro PHY_EQ_FREEZE_EN adds a freeze input that halts tap updates while tracking.
`timescale 1ns/1ps
module phy_eq_train_ctrl #(
    parameter int SAMPLE_W    = 10,
    parameter int AMP         = 200,
    parameter int ALIGN_DLY   = 2,
    parameter int WIN_LOG2    = 6,
    parameter int CONV_THR    = 24,
    parameter int GOOD_WIN    = 4,
    parameter int LOSS_THR    = 48,
    parameter int LOSS_WIN    = 2,
    parameter int TRAIN_MAX   = 4096,
    parameter int MAX_RETRAIN = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                sym_valid,
    input  logic [SAMPLE_W-1:0] eq_out,
`ifdef PHY_EQ_FREEZE_EN
    input  logic                freeze,
`endif
    output logic                eq_clr,
    output logic                train_en,
    output logic                decision_mode,
    output logic [SAMPLE_W-1:0] ref_symbol,
    output logic                locked,
    output logic                fail,
    output logic [2:0]          state,
    output logic [1:0]          retrain_cnt
);
    localparam int ERR_W  = SAMPLE_W + 1;
    localparam int ACC_W  = ERR_W + WIN_LOG2;
    localparam int TCNT_W = $clog2(TRAIN_MAX + 1);
    localparam int GCNT_W = $clog2(GOOD_WIN + 1);
    localparam int BCNT_W = $clog2(LOSS_WIN + 1);
    localparam logic [SAMPLE_W-1:0] POS_AMP = SAMPLE_W'(AMP);
    localparam logic [SAMPLE_W-1:0] NEG_AMP = SAMPLE_W'(-AMP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_TRAIN = 3'd2,
        S_TRACK = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t cur, nxt;

    logic [6:0]                          lfsr;
    logic [SAMPLE_W-1:0]                 ref_q;
    logic [ALIGN_DLY-1:0][SAMPLE_W-1:0]  dly;
    logic [ALIGN_DLY-1:0]                vld_pipe;
    logic [WIN_LOG2-1:0]                 win_cnt;
    logic [ACC_W-1:0]                    acc;
    logic [GCNT_W-1:0]                   good_cnt;
    logic [BCNT_W-1:0]                   bad_cnt;
    logic [TCNT_W-1:0]                   tcnt;
    logic [1:0]                          retrain_q;

    logic                frz;
`ifdef PHY_EQ_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    // Error datapath: tracking compares against the slicer, training against the aligned reference.
    logic [SAMPLE_W-1:0] decision, cmp_ref;
    logic [ERR_W-1:0]    err, abs_err, mean;
    logic [ACC_W-1:0]    acc_sum;
    logic                sample_en, win_end, good_win, bad_win;
    logic                converge, loss, timeout;
    logic [GCNT_W-1:0]   good_inc;
    logic [BCNT_W-1:0]   bad_inc;
    logic [TCNT_W-1:0]   tcnt_inc;

    assign decision  = eq_out[SAMPLE_W-1] ? NEG_AMP : POS_AMP;
    assign cmp_ref   = (cur == S_TRACK) ? decision : dly[ALIGN_DLY-1];
    assign err       = {cmp_ref[SAMPLE_W-1], cmp_ref} - {eq_out[SAMPLE_W-1], eq_out};
    assign abs_err   = err[ERR_W-1] ? (~err + 1'b1) : err;
    assign sample_en = sym_valid &&
                       ((cur == S_TRAIN && vld_pipe[ALIGN_DLY-1]) || cur == S_TRACK);
    assign acc_sum   = acc + ACC_W'(abs_err);
    assign mean      = acc_sum[ACC_W-1:WIN_LOG2];
    assign win_end   = sample_en && (win_cnt == '1);
    assign good_win  = (mean <= ERR_W'(CONV_THR));
    assign bad_win   = (mean >  ERR_W'(LOSS_THR));
    assign good_inc  = good_cnt + 1'b1;
    assign bad_inc   = bad_cnt + 1'b1;
    assign tcnt_inc  = tcnt + 1'b1;
    assign converge  = (cur == S_TRAIN) && win_end && good_win && (good_inc == GCNT_W'(GOOD_WIN));
    assign loss      = (cur == S_TRACK) && win_end && bad_win && (bad_inc == BCNT_W'(LOSS_WIN));
    assign timeout   = (cur == S_TRAIN) && sym_valid && (tcnt_inc == TCNT_W'(TRAIN_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt           = cur;
        eq_clr        = 1'b0;
        train_en      = 1'b0;
        decision_mode = 1'b0;
        locked        = 1'b0;
        fail          = 1'b0;
        case (cur)
            S_IDLE:  if (start) nxt = S_CLEAR;
            S_CLEAR: begin
                eq_clr = 1'b1;
                nxt    = S_TRAIN;
            end
            S_TRAIN: begin
                train_en = 1'b1;
                // Convergence outranks a timeout landing on the same strobe.
                if (converge)     nxt = S_TRACK;
                else if (timeout) nxt = S_FAIL;
            end
            S_TRACK: begin
                train_en      = ~frz;
                decision_mode = 1'b1;
                locked        = 1'b1;
                if (loss) nxt = (retrain_q == 2'(MAX_RETRAIN)) ? S_FAIL : S_CLEAR;
            end
            S_FAIL: begin
                fail = 1'b1;
                if (start) nxt = S_CLEAR;
            end
            default: nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= 7'h7F;
            ref_q     <= '0;
            dly       <= '0;
            vld_pipe  <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            tcnt      <= '0;
            retrain_q <= '0;
        end else if (abort) begin
            lfsr      <= 7'h7F;
            vld_pipe  <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            tcnt      <= '0;
            retrain_q <= '0;
        end else begin
            case (cur)
                S_IDLE, S_FAIL: if (start) retrain_q <= '0;
                S_CLEAR: begin
                    lfsr     <= 7'h7F;
                    vld_pipe <= '0;
                    win_cnt  <= '0;
                    acc      <= '0;
                    good_cnt <= '0;
                    bad_cnt  <= '0;
                    tcnt     <= '0;
                end
                S_TRAIN: if (sym_valid) begin
                    ref_q <= lfsr[6] ? POS_AMP : NEG_AMP;
                    lfsr  <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    tcnt  <= tcnt_inc;
                    for (int i = ALIGN_DLY - 1; i > 0; i--) begin
                        dly[i]      <= dly[i-1];
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                    dly[0]      <= lfsr[6] ? POS_AMP : NEG_AMP;
                    vld_pipe[0] <= 1'b1;
                end
                S_TRACK: begin
                    if (sym_valid) ref_q <= decision;
                    if (loss && retrain_q != 2'(MAX_RETRAIN)) retrain_q <= retrain_q + 1'b1;
                end
                default: ;
            endcase
            if (sample_en) begin
                win_cnt <= win_cnt + 1'b1;
                acc     <= win_end ? '0 : acc_sum;
                if (win_end && cur == S_TRAIN) good_cnt <= good_win ? good_inc : '0;
                if (win_end && cur == S_TRACK) bad_cnt  <= bad_win  ? bad_inc  : '0;
            end
        end
    end

    assign ref_symbol  = ref_q;
    assign state       = cur;
    assign retrain_cnt = retrain_q;

endmodule

// File: tb/tb_phy_eq_train_ctrl.sv
// Directed bench for phy_eq_train_ctrl: lock timing, tracking decisions, retrain chain, timeout, abort.
`timescale 1ns/1ps
module tb_phy_eq_train_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sym_valid = 1'b0;
    logic [9:0] eq_out = '0;
`ifdef PHY_EQ_FREEZE_EN
    logic       freeze = 1'b0;
    localparam int FRZ_N = 2;
`else
    localparam int FRZ_N = 0;
`endif
    logic       eq_clr, train_en, decision_mode, locked, fail;
    logic [9:0] ref_symbol;
    logic [2:0] state;
    logic [1:0] retrain_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int last_ref = 0;

    phy_eq_train_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sym_valid(sym_valid), .eq_out(eq_out),
`ifdef PHY_EQ_FREEZE_EN
        .freeze(freeze),
`endif
        .eq_clr(eq_clr), .train_en(train_en), .decision_mode(decision_mode),
        .ref_symbol(ref_symbol), .locked(locked), .fail(fail),
        .state(state), .retrain_cnt(retrain_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int eq;
        int exp_ref;
        int exp_locked;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic strobe(input int eq);
        @(negedge clk);
        sym_valid = 1'b1;
        eq_out    = 10'(eq);
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("clr_state", state, 1);
        check("clr_pulse", eq_clr, 1);
        check("clr_fail", fail, 0);
        check("clr_retrain", retrain_cnt, 0);
        @(posedge clk); #1;
        check("train_state", state, 2);
        check("clr_pulse_end", eq_clr, 0);
        check("train_en", train_en, 1);
        check("train_dmode", decision_mode, 0);
    endtask

    task automatic wait_clear(input int exp_retrain);
        check("rt_state", state, 1);
        check("rt_clr", eq_clr, 1);
        check("rt_locked", locked, 0);
        check("rt_cnt", retrain_cnt, exp_retrain);
        @(posedge clk); #1;
        check("rt_train", state, 2);
        check("rt_clr_end", eq_clr, 0);
    endtask

    // Ideal channel: eq_out echoes the reference issued two strobes earlier.
    task automatic train_ideal(input int n, input int exp_end);
        logic [6:0] m;
        int h0, h1, r;
        m = 7'h7F; h0 = 0; h1 = 0; r = 0;
        for (int i = 0; i < n; i++) begin
            r = m[6] ? 200 : -200;
            strobe(i >= 2 ? h1 : 0);
            check("train_ref", $signed(ref_symbol), r);
            if (i == n - 2) check("train_pre_end", state, 2);
            h1 = h0; h0 = r;
            m = {m[5:0], m[6] ^ m[5]};
        end
        last_ref = r;
        check("train_end_state", state, exp_end);
    endtask

    task automatic lose(input int n, input int exp_end);
        int e;
        for (int i = 0; i < n; i++) begin
            e = (i % 2 == 0) ? 150 : -150;
            strobe(e);
            check("dd_ref", $signed(ref_symbol), e > 0 ? 200 : -200);
            if (i == n - 2) check("loss_pre_end", state, 3);
        end
        check("loss_end_state", state, exp_end);
    endtask

    initial begin
        logic [6:0] m;
        int r;
        tbl[0] = '{eq:    0, exp_ref:  200, exp_locked: 1};
        tbl[1] = '{eq:    1, exp_ref:  200, exp_locked: 1};
        tbl[2] = '{eq:   -1, exp_ref: -200, exp_locked: 1};
        tbl[3] = '{eq:  511, exp_ref:  200, exp_locked: 1};
        tbl[4] = '{eq: -512, exp_ref: -200, exp_locked: 1};
        tbl[5] = '{eq:  150, exp_ref:  200, exp_locked: 1};
        tbl[6] = '{eq: -150, exp_ref: -200, exp_locked: 1};

        // Reset values
        #12;
        check("rst_state", state, 0);
        check("rst_eq_clr", eq_clr, 0);
        check("rst_train_en", train_en, 0);
        check("rst_dmode", decision_mode, 0);
        check("rst_ref", $signed(ref_symbol), 0);
        check("rst_locked", locked, 0);
        check("rst_fail", fail, 0);
        check("rst_retrain", retrain_cnt, 0);
        @(negedge clk); rst = 1'b0;

        // Asynchronous reset in the middle of training
        do_start();
        train_ideal(100, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_train_en", train_en, 0);
        check("mid_rst_ref", $signed(ref_symbol), 0);
        @(negedge clk); rst = 1'b0;

        // Ideal training: lock after ALIGN_DLY + 4 windows = 258 strobes
        do_start();
        train_ideal(258, 3);
        check("lock_locked", locked, 1);
        check("lock_dmode", decision_mode, 1);
        check("lock_train_en", train_en, 1);

`ifdef PHY_EQ_FREEZE_EN
        @(negedge clk); freeze = 1'b1;
        strobe(200);
        check("frz_train_en", train_en, 0);
        check("frz_ref_pos", $signed(ref_symbol), 200);
        strobe(-200);
        check("frz_ref_neg", $signed(ref_symbol), -200);
        check("frz_locked", locked, 1);
        @(negedge clk); freeze = 1'b0;
        @(posedge clk); #1;
        check("unfrz_train_en", train_en, 1);
`endif

        // Slicer decisions at sign boundaries and rails
        for (int i = 0; i < 7; i++) begin
            strobe(tbl[i].eq);
            check("tbl_ref", $signed(ref_symbol), tbl[i].exp_ref);
            check("tbl_locked", locked, tbl[i].exp_locked);
        end

        // Loss of lock -> retrain chain up to FAIL
        lose(121 - FRZ_N, 1);
        wait_clear(1);
        train_ideal(258, 3);
        lose(128, 1);
        wait_clear(2);
        train_ideal(258, 3);
        lose(128, 1);
        wait_clear(3);
        train_ideal(258, 3);
        lose(128, 4);
        check("fail_flag", fail, 1);
        check("fail_retrain", retrain_cnt, 3);
        check("fail_train_en", train_en, 0);
        check("fail_locked", locked, 0);
        strobe(300);
        check("fail_ref_held", $signed(ref_symbol), -200);
        check("fail_stays", state, 4);

        // Restart from FAIL, relock, one retrain, then abort together with start
        do_start();
        train_ideal(258, 3);
        lose(128, 1);
        wait_clear(1);
        train_ideal(258, 3);
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(posedge clk); #1; abort = 1'b0; start = 1'b0;
        check("abort_state", state, 0);
        check("abort_locked", locked, 0);
        check("abort_retrain", retrain_cnt, 0);
        check("abort_train_en", train_en, 0);
        check("abort_eq_clr", eq_clr, 0);
        check("abort_fail", fail, 0);
        strobe(-300);
        check("idle_ignores_sym", state, 0);
        check("idle_ref_held", $signed(ref_symbol), last_ref);

        // Training timeout with a dead channel
        do_start();
        m = 7'h7F; r = 0;
        for (int i = 0; i < 4096; i++) begin
            r = m[6] ? 200 : -200;
            m = {m[5:0], m[6] ^ m[5]};
            strobe(0);
            if (i == 4094) check("to_pre_state", state, 2);
        end
        check("to_state", state, 4);
        check("to_fail", fail, 1);
        check("to_train_en", train_en, 0);
        check("to_ref", $signed(ref_symbol), r);

        // start from FAIL with a strobe landing in CLEAR (dropped)
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("re_clr_state", state, 1);
        check("re_clr_fail", fail, 0);
        strobe(77);
        check("clr_drop_state", state, 2);
        check("clr_drop_ref", $signed(ref_symbol), r);
        train_ideal(258, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
